// File: rtl/bus_hs_pkg.sv
// Package: bus_hs_pkg
//
// Shared constants and helpers for the valid/ready elastic buffer family.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default payload width and beat capacity
//   clog2()                       : ceiling log2 usable in parameter expressions
package bus_hs_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 2;

    // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(3) = 2, clog2(9) = 4.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bus_hs_ring.sv
// Module: bus_hs_ring
//
// Circular register array that backs the head register of the elastic buffer.
// It holds no occupancy of its own: the parent knows how many beats are stored
// and never writes when full or reads when empty.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset (pointers only)
//   clr_i      in   1      synchronous pointer clear (flush)
//   wr_en_i    in   1      write wr_data_i at the write pointer and advance it
//   wr_data_i  in   WIDTH  payload to store
//   rd_en_i    in   1      advance the read pointer
//   rd_data_o  out  WIDTH  entry at the read pointer (combinational read)
module bus_hs_ring
    import bus_hs_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int ENTRIES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o
);

    localparam int PTRW = (ENTRIES > 1) ? clog2(ENTRIES) : 1;

    logic [PTRW-1:0]  wr_ptr_q;
    logic [PTRW-1:0]  wr_ptr_d;
    logic [PTRW-1:0]  rd_ptr_q;
    logic [PTRW-1:0]  rd_ptr_d;
    logic [WIDTH-1:0] mem_q [ENTRIES];

    // Pointers wrap at ENTRIES-1 rather than at a power of two.
    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] ptr);
        if (ptr == PTRW'(ENTRIES - 1)) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en_i) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (rd_en_i) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload storage carries no reset; stale entries are never read.
    always_ff @(posedge clk) begin
        if (wr_en_i && !clr_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/bus_valid_ready_elastic.sv
// Module: bus_valid_ready_elastic
//
// Multi-entry elastic buffer for a valid/ready bus. Every output (valid_o,
// data_o, ready_o, count_o) comes straight from a flop, so neither the forward
// nor the backward timing path crosses the buffer. Capacity is DEPTH beats:
// one output (head) register plus a DEPTH-1 entry ring. DEPTH>=2 sustains one
// beat per clock; DEPTH=1 alternates accept and emit.
//
// Ports
//   clk      in   1      rising-edge clock
//   rst      in   1      synchronous active-high reset, drops every held beat
//   flush_i  in   1      synchronous discard of all held beats; wins over acc/pop
//   valid_i  in   1      upstream beat valid
//   data_i   in   WIDTH  upstream payload
//   ready_o  out  1      upstream ready (registered, exact)
//   valid_o  out  1      downstream beat valid (registered)
//   data_o   out  WIDTH  downstream payload (registered)
//   ready_i  in   1      downstream ready
//   count_o  out  CNTW   beats currently held (registered)
module bus_valid_ready_elastic
    import bus_hs_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int CNTW  = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    input  logic             ready_i,
    output logic [CNTW-1:0]  count_o
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             ready_q;
    logic             ready_d;
    logic [CNTW-1:0]  count_q;
    logic [CNTW-1:0]  count_d;

    logic             acc;
    logic             pop;
    logic             store_empty;
    logic             store_wr;
    logic             store_rd;
    logic [WIDTH-1:0] store_rd_data;

    always_comb begin
        acc      = valid_i & ready_q;
        pop      = valid_q & ready_i;
        // Head is full whenever anything is held, so the ring holds count-1.
        store_empty = (count_q <= CNTW'(1));

        valid_d  = valid_q;
        data_d   = data_q;
        count_d  = count_q;
        store_wr = 1'b0;
        store_rd = 1'b0;

        // Head refill: oldest stored beat first, then the incoming beat.
        if (!valid_q || pop) begin
            if (!store_empty) begin
                data_d   = store_rd_data;
                valid_d  = 1'b1;
                store_rd = 1'b1;
                store_wr = acc;
            end else if (acc) begin
                data_d  = data_i;
                valid_d = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end else begin
            store_wr = acc;
        end

        unique case ({acc, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (flush_i) begin
            valid_d  = 1'b0;
            data_d   = data_q;
            count_d  = '0;
            store_wr = 1'b0;
            store_rd = 1'b0;
        end

        // Ready is computed from the next occupancy, so it is exact and the
        // ring can never be written when full.
        ready_d = (count_d < CNTW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            count_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ready_q <= ready_d;
            count_q <= count_d;
            data_q  <= data_d;
        end
    end

    generate
        if (DEPTH > 1) begin : g_ring
            bus_hs_ring #(
                .WIDTH   (WIDTH),
                .ENTRIES (DEPTH - 1)
            ) u_ring (
                .clk       (clk),
                .rst       (rst),
                .clr_i     (flush_i),
                .wr_en_i   (store_wr),
                .wr_data_i (data_i),
                .rd_en_i   (store_rd),
                .rd_data_o (store_rd_data)
            );
        end else begin : g_no_ring
            // Single-entry buffer: ready drops as soon as the head fills, so
            // the ring controls are never asserted.
            logic unused_store;
            assign unused_store  = store_wr ^ store_rd;
            assign store_rd_data = '0;
        end
    endgenerate

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign ready_o = ready_q;
    assign count_o = count_q;

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        count_q <= CNTW'(DEPTH));

    a_valid_count: assert property (@(posedge clk) disable iff (rst)
        valid_q == (count_q != '0));

endmodule

// File: tb/tb_bus_valid_ready_elastic.sv
module tb_bus_valid_ready_elastic;

    localparam int N = 5;

    function automatic int dep_of(input int i);
        case (i)
            0:       return 1;
            1:       return 2;
            2:       return 3;
            3:       return 4;
            default: return 8;
        endcase
    endfunction

    logic       clk = 1'b0;
    logic       rst;
    logic       fl   [N];
    logic       vi   [N];
    logic       ri   [N];
    logic [7:0] di   [N];
    logic       ro   [N];
    logic       vo   [N];
    logic [7:0] dout [N];
    logic [3:0] cnt  [N];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            localparam int DEP = dep_of(g);
            localparam int CW  = $clog2(DEP + 1);
            logic [CW-1:0] c;
            logic          r_o;
            logic          v_o;
            logic [7:0]    d_o;
            bus_valid_ready_elastic #(.WIDTH(8), .DEPTH(DEP)) u_dut (
                .clk     (clk),
                .rst     (rst),
                .flush_i (fl[g]),
                .valid_i (vi[g]),
                .data_i  (di[g]),
                .ready_o (r_o),
                .valid_o (v_o),
                .data_o  (d_o),
                .ready_i (ri[g]),
                .count_o (c)
            );
            assign ro[g]   = r_o;
            assign vo[g]   = v_o;
            assign dout[g] = d_o;
            assign cnt[g]  = 4'(c);
        end
    endgenerate

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            for (int d = 0; d < N; d++) begin
                tests++;
                if (vo[d] !== 1'b0 || ro[d] !== 1'b0 || cnt[d] !== 4'd0 || dout[d] !== 8'd0) begin
                    fails++;
                    $display("FAIL reset_hold dut%0d: got valid=%b ready=%b count=%0d data=%h, want 0 0 0 00",
                             d, vo[d], ro[d], cnt[d], dout[d]);
                end
            end
        end
        rst = 1'b0;
        step();
        for (int d = 0; d < N; d++) begin
            tests++;
            if (ro[d] !== 1'b1) begin
                fails++;
                $display("FAIL reset_release_ready dut%0d: got %b, want 1", d, ro[d]);
            end
            tests++;
            if (vo[d] !== 1'b0 || cnt[d] !== 4'd0) begin
                fails++;
                $display("FAIL reset_release_idle dut%0d: got valid=%b count=%0d, want 0 0", d, vo[d], cnt[d]);
            end
        end
    endtask

    task automatic test_streaming();
        ri[1] = 1'b1;
        vi[1] = 1'b1;
        for (int k = 0; k < 100; k++) begin
            di[1] = 8'(k);
            step();
            tests++;
            if (vo[1] !== 1'b1 || dout[1] !== 8'(k) || cnt[1] !== 4'd1 || ro[1] !== 1'b1) begin
                fails++;
                $display("FAIL stream beat %0d: got valid=%b data=%0d count=%0d ready=%b, want 1 %0d 1 1",
                         k, vo[1], dout[1], cnt[1], ro[1], k);
            end
        end
        vi[1] = 1'b0;
        step();
        tests++;
        if (vo[1] !== 1'b0 || cnt[1] !== 4'd0 || ro[1] !== 1'b1) begin
            fails++;
            $display("FAIL stream_drain: got valid=%b count=%0d ready=%b, want 0 0 1", vo[1], cnt[1], ro[1]);
        end
        ri[1] = 1'b0;
    endtask

    task automatic test_backpressure();
        ri[3] = 1'b0;
        vi[3] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            // beats 10..13 are taken; 14 is held by the source and never accepted
            di[3] = (c < 4) ? 8'(10 + c) : 8'd14;
            step();
            tests++;
            if (vo[3] !== 1'b1 || dout[3] !== 8'd10 || cnt[3] !== 4'((c < 3) ? c + 1 : 4)
                || ro[3] !== ((c < 3) ? 1'b1 : 1'b0)) begin
                fails++;
                $display("FAIL bp_fill cycle %0d: got valid=%b data=%0d count=%0d ready=%b, want 1 10 %0d %b",
                         c, vo[3], dout[3], cnt[3], ro[3], (c < 3) ? c + 1 : 4, (c < 3));
            end
        end
        vi[3] = 1'b0;
        ri[3] = 1'b1;
        for (int j = 1; j < 4; j++) begin
            step();
            tests++;
            if (vo[3] !== 1'b1 || dout[3] !== 8'(10 + j) || cnt[3] !== 4'(4 - j) || ro[3] !== 1'b1) begin
                fails++;
                $display("FAIL bp_drain %0d: got valid=%b data=%0d count=%0d ready=%b, want 1 %0d %0d 1",
                         j, vo[3], dout[3], cnt[3], ro[3], 10 + j, 4 - j);
            end
        end
        step();
        tests++;
        if (vo[3] !== 1'b0 || cnt[3] !== 4'd0) begin
            fails++;
            $display("FAIL bp_empty: got valid=%b count=%0d, want 0 0", vo[3], cnt[3]);
        end
        ri[3] = 1'b0;
    endtask

    task automatic test_flush();
        ri[3] = 1'b0;
        vi[3] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            di[3] = 8'(20 + k);
            step();
        end
        tests++;
        if (vo[3] !== 1'b1 || dout[3] !== 8'd20 || cnt[3] !== 4'd3 || ro[3] !== 1'b1) begin
            fails++;
            $display("FAIL flush_prefill: got valid=%b data=%0d count=%0d ready=%b, want 1 20 3 1",
                     vo[3], dout[3], cnt[3], ro[3]);
        end
        fl[3] = 1'b1;
        di[3] = 8'h99;
        step();
        fl[3] = 1'b0;
        vi[3] = 1'b0;
        tests++;
        if (vo[3] !== 1'b0 || cnt[3] !== 4'd0 || ro[3] !== 1'b1) begin
            fails++;
            $display("FAIL flush_edge: got valid=%b count=%0d ready=%b, want 0 0 1", vo[3], cnt[3], ro[3]);
        end
        ri[3] = 1'b1;
        step();
        tests++;
        if (vo[3] !== 1'b0 || cnt[3] !== 4'd0) begin
            fails++;
            $display("FAIL flush_no_ghost: got valid=%b count=%0d data=%h, want 0 0", vo[3], cnt[3], dout[3]);
        end
        vi[3] = 1'b1;
        di[3] = 8'h30;
        step();
        vi[3] = 1'b0;
        tests++;
        if (vo[3] !== 1'b1 || dout[3] !== 8'h30 || cnt[3] !== 4'd1) begin
            fails++;
            $display("FAIL flush_after: got valid=%b data=%h count=%0d, want 1 30 1", vo[3], dout[3], cnt[3]);
        end
        step();
        tests++;
        if (vo[3] !== 1'b0 || cnt[3] !== 4'd0) begin
            fails++;
            $display("FAIL flush_after_drain: got valid=%b count=%0d, want 0 0", vo[3], cnt[3]);
        end
        ri[3] = 1'b0;
    endtask

    task automatic test_depth1();
        ri[0] = 1'b1;
        vi[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            di[0] = 8'(40 + k);
            step();
            tests++;
            if (vo[0] !== 1'b1 || dout[0] !== 8'(40 + k) || ro[0] !== 1'b0 || cnt[0] !== 4'd1) begin
                fails++;
                $display("FAIL d1_emit %0d: got valid=%b data=%0d ready=%b count=%0d, want 1 %0d 0 1",
                         k, vo[0], dout[0], ro[0], cnt[0], 40 + k);
            end
            if (k == 9) vi[0] = 1'b0;
            step();
            tests++;
            if (vo[0] !== 1'b0 || ro[0] !== 1'b1 || cnt[0] !== 4'd0) begin
                fails++;
                $display("FAIL d1_gap %0d: got valid=%b ready=%b count=%0d, want 0 1 0", k, vo[0], ro[0], cnt[0]);
            end
        end
        ri[0] = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] mm [N][16];
        int         msz  [N];
        int         mrd  [N];
        int         pops [N];
        logic       mer  [N];
        logic       a;
        logic       p;
        bit         all_done;
        for (int d = 0; d < N; d++) begin
            msz[d] = 0; mrd[d] = 0; pops[d] = 0; mer[d] = 1'b1;
        end
        all_done = 1'b0;
        for (int cyc = 0; cyc < 60000; cyc++) begin
            all_done = 1'b1;
            for (int d = 0; d < N; d++) if (pops[d] < 10000) all_done = 1'b0;
            if (all_done) break;
            rst = (cyc == 5000 || cyc == 5001);
            for (int d = 0; d < N; d++) begin
                vi[d] = ($urandom_range(0, 3) != 0);
                ri[d] = ($urandom_range(0, 3) != 0);
                di[d] = 8'($urandom);
                fl[d] = ($urandom_range(0, 299) == 0);
            end
            @(posedge clk);
            for (int d = 0; d < N; d++) begin
                if (rst) begin
                    msz[d] = 0; mrd[d] = 0; mer[d] = 1'b0;
                end else if (fl[d]) begin
                    msz[d] = 0; mrd[d] = 0; mer[d] = 1'b1;
                end else begin
                    a = vi[d] & mer[d];
                    p = (msz[d] != 0) & ri[d];
                    if (a) mm[d][(mrd[d] + msz[d]) % 16] = di[d];
                    if (p) begin
                        mrd[d] = (mrd[d] + 1) % 16;
                        pops[d]++;
                    end
                    msz[d] = msz[d] + int'(a) - int'(p);
                    mer[d] = (msz[d] < dep_of(d));
                end
            end
            #1;
            for (int d = 0; d < N; d++) begin
                tests++;
                if (cnt[d] !== 4'(msz[d]) || vo[d] !== (msz[d] != 0) || ro[d] !== mer[d]) begin
                    fails++;
                    $display("FAIL rand_ctrl dut%0d cyc %0d: got count=%0d valid=%b ready=%b, want %0d %b %b",
                             d, cyc, cnt[d], vo[d], ro[d], msz[d], (msz[d] != 0), mer[d]);
                end
                tests++;
                if (cnt[d] > 4'(dep_of(d))) begin
                    fails++;
                    $display("FAIL rand_bound dut%0d cyc %0d: got count=%0d, want <= %0d", d, cyc, cnt[d], dep_of(d));
                end
                if (msz[d] != 0) begin
                    tests++;
                    if (dout[d] !== mm[d][mrd[d]]) begin
                        fails++;
                        $display("FAIL rand_data dut%0d cyc %0d: got %h, want %h", d, cyc, dout[d], mm[d][mrd[d]]);
                    end
                end
            end
            if (fails > 50) break;
        end
        rst = 1'b0;
        for (int d = 0; d < N; d++) begin
            vi[d] = 1'b0; ri[d] = 1'b0; fl[d] = 1'b0;
        end
        all_done = 1'b1;
        for (int d = 0; d < N; d++) if (pops[d] < 10000) all_done = 1'b0;
        tests++;
        if (!all_done) begin
            fails++;
            $display("FAIL rand_progress: got pops %0d %0d %0d %0d %0d, want >= 10000 each",
                     pops[0], pops[1], pops[2], pops[3], pops[4]);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < N; d++) begin
            fl[d] = 1'b0; vi[d] = 1'b0; ri[d] = 1'b0; di[d] = 8'd0;
        end
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_depth1();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
